// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-result formatting and
// a load-data wait handshake that freezes the upstream pipeline.
module mem_wb_stage #(
   parameter int LOAD_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_we,
   input  logic [4:0]  m_waddr,
   input  logic [31:0] m_wdata,
   input  logic        m_ld,
   input  logic [2:0]  m_ldtype,
   input  logic [1:0]  m_addrlo,
   input  logic        stall_in,
   input  logic        flush,
   input  logic [31:0] dm_rdata,
   input  logic        dm_rvalid,
   output logic        we,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        wb_stall,
   output logic        ld_err
);

   typedef enum logic [1:0] {
      EMPTY,
      ALU,
      LDWAIT,
      LDDONE
   } state_t;

   localparam int CW = $clog2(LOAD_TIMEOUT + 2);
   localparam bit TO_EN = (LOAD_TIMEOUT > 0);
   localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? LOAD_TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] TO_MAX = CW'(LOAD_TIMEOUT);

   state_t state, state_nx;

   logic          we_r;
   logic [4:0]    waddr_r;
   logic [31:0]   wdata_r;
   logic [2:0]    ldtype_r;
   logic [1:0]    alo_r;
   logic [31:0]   rd_hold;
   logic [CW-1:0] wcnt;

   logic          waiting;
   logic          take;
   logic [31:0]   ld_src;
   logic [31:0]   ld_val;

   // rt arrives in wdata_r so LWL/LWR can merge into the old value
   function automatic logic [31:0] fmt(
      input logic [2:0]  t,
      input logic [1:0]  a,
      input logic [31:0] d,
      input logic [31:0] rt
   );
      logic [31:0] sd;
      logic [7:0]  b;
      logic [15:0] h;
      sd = d >> {a, 3'b000};
      b = sd[7:0];
      h = a[1] ? d[31:16] : d[15:0];
      fmt = d;
      case (t)
         3'b001: fmt = {{24{b[7]}}, b};
         3'b010: fmt = {24'h0, b};
         3'b011: fmt = {{16{h[15]}}, h};
         3'b100: fmt = {16'h0, h};
         3'b101:
            case (a)
               2'd0: fmt = {d[7:0], rt[23:0]};
               2'd1: fmt = {d[15:0], rt[15:0]};
               2'd2: fmt = {d[23:0], rt[7:0]};
               default: fmt = d;
            endcase
         3'b110:
            case (a)
               2'd0: fmt = d;
               2'd1: fmt = {rt[31:24], d[31:8]};
               2'd2: fmt = {rt[31:16], d[31:16]};
               default: fmt = {rt[31:8], d[31:24]};
            endcase
         default: fmt = d;
      endcase
   endfunction

   assign waiting = (state == LDWAIT) && !dm_rvalid;
   assign take = !waiting && !flush && !stall_in;
   assign ld_src = (state == LDDONE) ? rd_hold : dm_rdata;
   assign ld_val = fmt(ldtype_r, alo_r, ld_src, wdata_r);
   assign waddr = waddr_r;
   assign wb_stall = waiting;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= EMPTY;
         we_r     <= 1'b0;
         waddr_r  <= 5'd0;
         wdata_r  <= 32'd0;
         ldtype_r <= 3'd0;
         alo_r    <= 2'd0;
         rd_hold  <= 32'd0;
         wcnt     <= '0;
      end else begin
         state <= state_nx;
         if (state == LDWAIT && dm_rvalid)
            rd_hold <= dm_rdata;
         if (take) begin
            we_r     <= m_we;
            waddr_r  <= m_waddr;
            wdata_r  <= m_wdata;
            ldtype_r <= m_ldtype;
            alo_r    <= m_addrlo;
         end else if (state_nx == EMPTY) begin
            we_r <= 1'b0;
         end
         // saturate so the timeout pulse fires only once per load
         if (TO_EN && waiting && !flush) begin
            if (wcnt != TO_MAX)
               wcnt <= wcnt + 1'b1;
         end else begin
            wcnt <= '0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      we = 1'b0;
      wdata = 32'd0;
      ld_err = 1'b0;
      priority case (1'b1)
         waiting:          state_nx = flush ? EMPTY : LDWAIT;
         flush | stall_in: state_nx = EMPTY;
         m_ld:             state_nx = LDWAIT;
         default:          state_nx = ALU;
      endcase
      unique case (state)
         ALU: begin
            we = we_r;
            wdata = wdata_r;
         end
         LDWAIT: begin
            we = we_r & dm_rvalid;
            wdata = ld_val;
            ld_err = TO_EN && waiting && (wcnt == TO_LAST);
         end
         LDDONE: begin
            we = we_r;
            wdata = ld_val;
         end
         default: ;
      endcase
   end

endmodule
